// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - M-stage load/store unit bridging the pipeline to the dmem valid/grant bus
//
// Purpose: turns the M-stage load/store into one bus transaction (request held until grant,
// then read data on rvalid), stalls F/D/E/M while it is outstanding, extends load data for
// the M/W register and reports misaligned / bad-funct3 / timed-out accesses.
//
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   mem_req, mem_we, funct3         M-stage access request, store flag, Instr_M[14:12]
//   addr, wdata                     byte address, unaligned store data (low bytes valid)
//   stall                           hold F/D/E/M this cycle
//   load_valid, rdata_ext           1-cycle pulse with extended load data
//   exc_valid, exc_cause            1-cycle exception pulse; 01 misaligned, 10 bad funct3, 11 timeout
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata               bus request and its registered fields
//   bus_gnt, bus_rvalid, bus_rdata  bus grant, read-data valid, read word
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] rdata_ext,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             to_q, to_d;
  logic [31:0]      rdata_q;

  logic        bad_f3, misal, acc_ok, start, cnt_last, capture;
  logic [3:0]  be_new;
  logic [31:0] wd_new, ext_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Access legality; an unsupported funct3 outranks misalignment.
  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (funct3)
      3'b000: ;
      3'b100: bad_f3 = mem_we;
      3'b001: misal = addr[0];
      3'b101: begin
        bad_f3 = mem_we;
        misal  = addr[0];
      end
      3'b010: misal = |addr[1:0];
      default: bad_f3 = 1'b1;
    endcase
  end

  assign acc_ok = ~bad_f3 & ~misal;
  assign start  = (state_q == S_IDLE) & mem_req & acc_ok;

  // Byte enables and lane-replicated store data, both by access size.
  always_comb begin
    be_new = 4'b1111;
    wd_new = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_new = 4'b0001 << addr[1:0];
        wd_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new = 4'b0011 << {addr[1], 1'b0};
        wd_new = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extension uses the latched offset/funct3, not the live M-stage inputs.
  always_comb begin
    rd_byte  = bus_rdata[{lo_q, 3'b000} +: 8];
    rd_half  = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext_data = bus_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext_data = {24'd0, rd_byte};
      3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext_data = {16'd0, rd_half};
      default: ext_data = bus_rdata;
    endcase
  end

  assign cnt_last = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    to_d       = 1'b0;
    stall      = 1'b0;
    load_valid = 1'b0;
    exc_valid  = 1'b0;
    exc_cause  = 2'b00;
    bus_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req && !acc_ok) begin
          exc_valid = 1'b1;
          exc_cause = bad_f3 ? 2'b10 : 2'b01;
        end
        if (start) begin
          stall   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt && (we_q || bus_rvalid)) begin
          capture = ~we_q;
          state_d = S_DONE;
        end else if (cnt_last) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else if (bus_gnt) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (cnt_last) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_valid = ~we_q & ~to_q;
        exc_valid  = to_q;
        exc_cause  = to_q ? 2'b11 : 2'b00;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      lo_q    <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      if (start) begin
        we_q   <= mem_we;
        f3_q   <= funct3;
        lo_q   <= addr[1:0];
        addr_q <= {addr[31:2], 2'b00};
        be_q   <= be_new;
        wd_q   <= wd_new;
        cnt_q  <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT_R) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture) begin
        rdata_q <= ext_data;
      end
    end
  end

  assign rdata_ext = rdata_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wd_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, load_valid, exc_valid, bus_req, bus_we;
  logic [31:0] rdata_ext, bus_addr, bus_wdata;
  logic [1:0]  exc_cause;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int failures = 0;

  lsu_mem_stage #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_valid(load_valid),
    .rdata_ext(rdata_ext), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        exc;
    logic [1:0]  cause;
    int          stall;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rext;
  } vec_t;

  typedef struct {
    int          stall_cyc;
    int          exc_cnt;
    int          lv_cnt;
    logic [1:0]  cause;
    bit          req_seen;
    bit          unstable;
    bit          hang;
    logic        bwe;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    logic [31:0] rext;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [31:0] exp_rext);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".load_valid"}, load_valid, 0);
    chk({tag, ".exc_valid"}, exc_valid, 0);
    chk({tag, ".exc_cause"}, exc_cause, 0);
    chk({tag, ".bus_req"}, bus_req, 0);
    chk({tag, ".rdata_ext"}, rdata_ext, exp_rext);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag, 32'd0);
    chk({tag, ".bus_we"}, bus_we, 0);
    chk({tag, ".bus_addr"}, bus_addr, 0);
    chk({tag, ".bus_be"}, bus_be, 0);
    chk({tag, ".bus_wdata"}, bus_wdata, 0);
  endtask

  // Reference: access rules expressed as size/offset arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    int          n, lo, total;
    bit          legal;
    logic [31:0] sh, mask;
    e = v;
    n = 1 << v.f3[1:0];
    lo = int'(v.addr % 4);
    legal = v.we ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.exc = 1'b0; e.cause = 2'd0; e.stall = 0; e.be = 4'd0; e.bwdata = 32'd0; e.rext = 32'd0;
    if (!legal) begin
      e.exc = 1'b1; e.cause = 2'd2;
    end else if ((v.addr % n) != 0) begin
      e.exc = 1'b1; e.cause = 2'd1;
    end else begin
      total = v.gd + 1 + (v.we ? 0 : v.rd);
      if (total > 16) begin
        e.exc = 1'b1; e.cause = 2'd3; e.stall = 17;
      end else begin
        e.stall = total + 1;
      end
      e.be = 4'(((1 << n) - 1) << lo);
      if (n == 1) e.bwdata = {24'd0, v.wdata[7:0]} * 32'h0101_0101;
      else if (n == 2) e.bwdata = {16'd0, v.wdata[15:0]} * 32'h0001_0001;
      else e.bwdata = v.wdata;
      sh = v.rdata >> (8 * lo);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      e.rext = sh & mask;
      if (n < 4 && !v.f3[2] && e.rext[8 * n - 1]) e.rext = e.rext | ~mask;
    end
    return e;
  endfunction

  // Drives one access and plays the bus: grant after gd request cycles, rvalid rd cycles after grant.
  task automatic do_access(input vec_t v, output obs_t o);
    int reqc, gat;
    bit done;
    o.stall_cyc = 0; o.exc_cnt = 0; o.lv_cnt = 0; o.cause = 2'd0; o.req_seen = 0;
    o.unstable = 0; o.hang = 0; o.bwe = 1'b0; o.baddr = 32'd0; o.bwdata = 32'd0;
    o.be = 4'd0; o.rext = 32'd0;
    reqc = 0; gat = -1; done = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    bus_rdata = v.rdata;
    for (int cyc = 0; cyc < 60; cyc++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      if (bus_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1; o.bwe = bus_we; o.baddr = bus_addr; o.be = bus_be; o.bwdata = bus_wdata;
        end else if (o.bwe !== bus_we || o.baddr !== bus_addr || o.be !== bus_be || o.bwdata !== bus_wdata) begin
          o.unstable = 1;
        end
        if (reqc == v.gd) begin
          bus_gnt = 1'b1; gat = cyc;
        end
        reqc++;
      end
      if (!v.we && gat >= 0 && cyc == gat + v.rd) bus_rvalid = 1'b1;
      #1;
      if (exc_valid) begin o.exc_cnt++; o.cause = exc_cause; end
      if (load_valid) begin o.lv_cnt++; o.rext = rdata_ext; end
      if (!stall) begin done = 1; break; end
      o.stall_cyc++;
      @(negedge clk);
    end
    if (!done) o.hang = 1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input obs_t o, input string tag);
    chk({tag, ".hang"}, o.hang, 0);
    chk({tag, ".exc_cnt"}, o.exc_cnt, v.exc);
    if (v.exc) chk({tag, ".cause"}, o.cause, v.cause);
    chk({tag, ".stall_cyc"}, o.stall_cyc, v.stall);
    chk({tag, ".lv_cnt"}, o.lv_cnt, (!v.we && !v.exc) ? 1 : 0);
    if (v.exc && v.cause != 2'd3) begin
      chk({tag, ".no_bus_req"}, o.req_seen, 0);
    end else begin
      chk({tag, ".bus_req_seen"}, o.req_seen, 1);
      chk({tag, ".bus_be"}, o.be, v.be);
      chk({tag, ".bus_addr"}, o.baddr, v.addr & 32'hFFFF_FFFC);
      chk({tag, ".bus_we"}, o.bwe, v.we);
      if (v.we) chk({tag, ".bus_wdata"}, o.bwdata, v.bwdata);
      chk({tag, ".fields_stable"}, o.unstable, 0);
    end
    if (!v.we && !v.exc) chk({tag, ".rdata_ext"}, o.rext, v.rext);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    vec_t v;
    obs_t o;

    //           we    f3    addr          wdata         rdata        gd   rd  exc  cause st  be       bwdata        rext
    tbl[0]  = '{1'b1, 3'd0, 32'h1000_0003, 32'h0000_00A5, 32'h0,        0,   0, 1'b0, 2'd0, 2, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    tbl[1]  = '{1'b0, 3'd1, 32'h1000_0002, 32'h0,         32'h8001_1234, 0,  0, 1'b0, 2'd0, 2, 4'b1100, 32'h0,         32'hFFFF_8001};
    tbl[2]  = '{1'b0, 3'd4, 32'h1000_0001, 32'h0,         32'h0000_F700, 3,  2, 1'b0, 2'd0, 7, 4'b0010, 32'h0,         32'h0000_00F7};
    tbl[3]  = '{1'b0, 3'd2, 32'h1000_0001, 32'h0,         32'h0,        0,   0, 1'b1, 2'd1, 0, 4'b0000, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 3'd3, 32'h1000_0000, 32'h0,         32'h0,        0,   0, 1'b1, 2'd2, 0, 4'b0000, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 3'd1, 32'h1000_0006, 32'h1234_BEEF, 32'h0,        1,   0, 1'b0, 2'd0, 3, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    tbl[6]  = '{1'b1, 3'd2, 32'h2000_0004, 32'hDEAD_BEEF, 32'h0,        0,   0, 1'b0, 2'd0, 2, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b1, 3'd4, 32'h1000_0000, 32'h0,         32'h0,        0,   0, 1'b1, 2'd2, 0, 4'b0000, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 3'd1, 32'h1000_0001, 32'h0,         32'h0,        0,   0, 1'b1, 2'd1, 0, 4'b0000, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 3'd0, 32'h1000_0003, 32'h0,         32'h8000_0000, 0,  1, 1'b0, 2'd0, 3, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[10] = '{1'b0, 3'd5, 32'h1000_0000, 32'h0,         32'h1234_9ABC, 2,  0, 1'b0, 2'd0, 4, 4'b0011, 32'h0,         32'h0000_9ABC};
    tbl[11] = '{1'b0, 3'd7, 32'h1000_0003, 32'h0,         32'h0,        0,   0, 1'b1, 2'd2, 0, 4'b0000, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 3'd2, 32'h1000_0008, 32'h0,         32'hCAFE_F00D, 0,  3, 1'b0, 2'd0, 5, 4'b1111, 32'h0,         32'hCAFE_F00D};
    tbl[13] = '{1'b1, 3'd0, 32'h1000_0002, 32'h0000_005A, 32'h0,        100, 0, 1'b1, 2'd3, 17, 4'b0100, 32'h5A5A_5A5A, 32'h0};
    tbl[14] = '{1'b0, 3'd2, 32'h1000_000C, 32'h0,         32'h0,        0, 100, 1'b1, 2'd3, 17, 4'b1111, 32'h0,         32'h0};
    tbl[15] = '{1'b0, 3'd1, 32'h1000_0000, 32'h0,         32'h0001_7FFF, 0,  0, 1'b0, 2'd0, 2, 4'b0011, 32'h0,         32'h0000_7FFF};
    tbl[16] = '{1'b0, 3'd0, 32'h1000_0001, 32'h0,         32'h0000_F700, 0,  0, 1'b0, 2'd0, 2, 4'b0010, 32'h0,         32'hFFFF_FFF7};
    tbl[17] = '{1'b1, 3'd2, 32'h3000_0000, 32'h0123_4567, 32'h0,        15,  0, 1'b0, 2'd0, 17, 4'b1111, 32'h0123_4567, 32'h0};

    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    n_rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      do_access(tbl[i], o);
      check_vec(tbl[i], o, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 80; i++) begin
      v.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (v.we) v.f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: v.f3 = 3'd0;
            1: v.f3 = 3'd1;
            2: v.f3 = 3'd2;
            3: v.f3 = 3'd4;
            default: v.f3 = 3'd5;
          endcase
        end
      end else begin
        v.f3 = 3'($urandom_range(0, 7));
      end
      v.addr = $urandom();
      if ($urandom_range(0, 2) != 0) v.addr = v.addr & ~32'(v.f3[1] ? 3 : (v.f3[0] ? 1 : 0));
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.gd = ($urandom_range(0, 9) == 0) ? 14 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 4));
      v.rd = ($urandom_range(0, 9) == 0) ? 12 + int'($urandom_range(0, 6)) : int'($urandom_range(0, 3));
      v = model(v);
      do_access(v, o);
      check_vec(v, o, $sformatf("rnd%0d", i));
      mem_req = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Late rvalid after a timeout must not disturb the held load data.
    v = '{1'b0, 3'd2, 32'h1000_0020, 32'h0, 32'h1111_2222, 0, 0, 1'b0, 2'd0, 2, 4'b1111, 32'h0, 32'h1111_2222};
    do_access(v, o);
    check_vec(v, o, "late.pre");
    v = '{1'b0, 3'd2, 32'h1000_0024, 32'h0, 32'h0, 0, 100, 1'b1, 2'd3, 17, 4'b1111, 32'h0, 32'h0};
    do_access(v, o);
    check_vec(v, o, "late.to");
    @(negedge clk);
    mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #1 chk_quiet("late.rv", 32'h1111_2222);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1 chk_quiet("late.after", 32'h1111_2222);

    // Reset while waiting for read data.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'd2; addr = 32'h1000_0010; bus_rdata = 32'h1357_2468;
    @(negedge clk);
    #1 chk("rst.in_req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1 chk("rst.wait_stall", stall, 1);
    chk("rst.wait_req", bus_req, 0);
    n_rst = 1'b0; mem_req = 1'b0;
    #1 chk_all_zero("rst.during");
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1;
    #1 chk_all_zero("rst.late_rv");
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1 chk_all_zero("rst.idle");

    v = tbl[0];
    do_access(v, o);
    check_vec(v, o, "rst.next");
    mem_req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
